// File: rtl/sampletest_multi_pkg.sv
// rtl/sampletest_multi_pkg.sv - shared widths, edge table and stage-C payload for sampletest_multi
package sampletest_multi_pkg;

  localparam int ST_SIGFIG = 24;
  localparam int ST_AXIS   = 3;
  localparam int ST_COLORS = 3;
  localparam int ST_LANES  = 4;

  localparam int EDGES = 3;
  localparam int EW    = ST_SIGFIG - 4;
  localparam int DW    = 2 * EW + 1;

  // Edge e runs from vertex EDGE_A[e] to vertex EDGE_B[e]
  localparam int EDGE_A [EDGES] = '{0, 1, 2};
  localparam int EDGE_B [EDGES] = '{1, 2, 0};

  typedef struct packed {
    logic [ST_LANES*ST_AXIS*ST_SIGFIG-1:0] hit;
    logic [ST_COLORS*ST_SIGFIG-1:0]        color;
    logic [ST_LANES-1:0]                   mask;
  } payload_t;

  function automatic logic [31:0] lane_count(input logic [ST_LANES-1:0] m);
    lane_count = 32'($countones(m));
  endfunction

endpackage

// File: rtl/sampletest_obuf.sv
// rtl/sampletest_obuf.sv - output FIFO with occupancy count for credit-based back-pressure
module sampletest_obuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  input  logic [WIDTH-1:0]           s_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [WIDTH-1:0]           m_tdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    bump = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign m_tvalid = (count != '0);
  assign pop      = m_tready && m_tvalid;
  assign m_tdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (s_tvalid) wr_ptr <= bump(wr_ptr);
      if (pop)      rd_ptr <= bump(rd_ptr);
      count <= count + CW'(s_tvalid) - CW'(pop);
    end
  end

  // Writer never exceeds free space, so a write at full always pairs with a pop
  always_ff @(posedge clk) begin
    if (s_tvalid) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/sampletest_multi.sv
// rtl/sampletest_multi.sv - multi-lane triangle sample test; SAMPLETEST_MULTI_CNT_EN adds tested/hit counters
module sampletest_multi
  import sampletest_multi_pkg::*;
#(
  parameter int SIGFIG     = ST_SIGFIG,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = ST_AXIS,
  parameter int COLORS     = ST_COLORS,
  parameter int LANES      = ST_LANES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R16S,
  input  logic [COLORS*SIGFIG-1:0]      color_R16U,
  input  logic [LANES*2*SIGFIG-1:0]     sample_R16S,
  input  logic [LANES-1:0]              sampValid_R16H,
  input  logic                          cull_R16H,
  input  logic                          valid_R16H,
  output logic                          ready_R16H,
  output logic [LANES*AXIS*SIGFIG-1:0]  hit_R19S,
  output logic [COLORS*SIGFIG-1:0]      color_R19U,
  output logic [LANES-1:0]              hitMask_R19H,
  output logic                          valid_R19H,
  input  logic                          ready_R19H
`ifdef SAMPLETEST_MULTI_CNT_EN
 ,output logic [31:0]                   cntTested_R19U,
  output logic [31:0]                   cntHit_R19U
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PL = $bits(payload_t);

  logic a_vld, b_vld, c_vld, up;
  logic [1:0] inflight;

  logic signed [EW-1:0] a_sx [LANES][VERTS];
  logic signed [EW-1:0] a_sy [LANES][VERTS];
  logic [LANES*2*SIGFIG-1:0] a_samp, b_samp;
  logic [SIGFIG-1:0]         a_z, b_z;
  logic [COLORS*SIGFIG-1:0]  a_color, b_color;
  logic [LANES-1:0]          a_sv, b_sv;
  logic                      a_cull, b_cull;

  logic signed [DW-1:0] dist_n [LANES][EDGES];
  logic signed [DW-1:0] b_dist [LANES][EDGES];

  logic [LANES-1:0]             all_neg, all_pos, mask_n;
  logic [LANES*AXIS*SIGFIG-1:0] hit_n;
  payload_t                     c_pay;
  payload_t                     fifo_pl;
  logic [PL-1:0]                fifo_out;
  logic [CW-1:0]                fifo_count;
  logic                         fifo_wr;

  assign inflight   = {1'b0, a_vld} + {1'b0, b_vld} + {1'b0, c_vld};
  assign ready_R16H = up && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_vld <= 1'b0;
      b_vld <= 1'b0;
      c_vld <= 1'b0;
      up    <= 1'b0;
    end else begin
      a_vld <= valid_R16H && ready_R16H;
      b_vld <= a_vld;
      c_vld <= b_vld;
      up    <= 1'b1;
    end
  end

  // Stage A: sample-relative vertices, truncated so the cross products stay exact
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      for (int v = 0; v < VERTS; v++) begin
        a_sx[l][v] <= EW'(tri_R16S[(v*AXIS+0)*SIGFIG +: SIGFIG] - sample_R16S[(l*2+0)*SIGFIG +: SIGFIG]);
        a_sy[l][v] <= EW'(tri_R16S[(v*AXIS+1)*SIGFIG +: SIGFIG] - sample_R16S[(l*2+1)*SIGFIG +: SIGFIG]);
      end
    end
    a_samp  <= sample_R16S;
    a_z     <= tri_R16S[2*SIGFIG +: SIGFIG];
    a_color <= color_R16U;
    a_sv    <= sampValid_R16H;
    a_cull  <= cull_R16H;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int e = 0; e < EDGES; e++) begin
        dist_n[l][e] = DW'(a_sx[l][EDGE_A[e]]) * DW'(a_sy[l][EDGE_B[e]])
                     - DW'(a_sx[l][EDGE_B[e]]) * DW'(a_sy[l][EDGE_A[e]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    b_dist  <= dist_n;
    b_samp  <= a_samp;
    b_z     <= a_z;
    b_color <= a_color;
    b_sv    <= a_sv;
    b_cull  <= a_cull;
  end

  // A zero distance fails both the all-negative and all-positive tests
  always_comb begin
    all_neg = '1;
    all_pos = '1;
    mask_n  = '0;
    hit_n   = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int e = 0; e < EDGES; e++) begin
        all_neg[l] = all_neg[l] & b_dist[l][e][DW-1];
        all_pos[l] = all_pos[l] & !b_dist[l][e][DW-1] & (b_dist[l][e] != '0);
      end
      mask_n[l] = b_sv[l] && (all_neg[l] || (!b_cull && all_pos[l]));
      hit_n[(l*AXIS+0)*SIGFIG +: SIGFIG] = b_samp[(l*2+0)*SIGFIG +: SIGFIG];
      hit_n[(l*AXIS+1)*SIGFIG +: SIGFIG] = b_samp[(l*2+1)*SIGFIG +: SIGFIG];
      hit_n[(l*AXIS+2)*SIGFIG +: SIGFIG] = b_z;
    end
  end

  always_ff @(posedge clk) begin
    c_pay.hit   <= hit_n;
    c_pay.color <= b_color;
    c_pay.mask  <= mask_n;
  end

  assign fifo_wr = c_vld && (c_pay.mask != '0);

  sampletest_obuf #(
    .WIDTH (PL),
    .DEPTH (FIFO_DEPTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (fifo_wr),
    .s_tdata  (c_pay),
    .m_tvalid (valid_R19H),
    .m_tready (ready_R19H),
    .m_tdata  (fifo_out),
    .count    (fifo_count)
  );

  assign fifo_pl      = payload_t'(fifo_out);
  assign hit_R19S     = fifo_pl.hit;
  assign color_R19U   = fifo_pl.color;
  assign hitMask_R19H = fifo_pl.mask;

`ifdef SAMPLETEST_MULTI_CNT_EN
  logic [LANES-1:0] c_sv;

  always_ff @(posedge clk) begin
    c_sv <= b_sv;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cntTested_R19U <= '0;
      cntHit_R19U    <= '0;
    end else if (c_vld) begin
      cntTested_R19U <= cntTested_R19U + lane_count(c_sv);
      if (fifo_wr) cntHit_R19U <= cntHit_R19U + lane_count(c_pay.mask);
    end
  end
`endif

  // Only vertex 0 contributes z; the other z fields and RADIX are intentionally ignored
  logic [31:0] unused_radix;
  logic        unused_tri_z;
  assign unused_radix = RADIX;
  always_comb begin
    unused_tri_z = 1'b0;
    for (int v = 1; v < VERTS; v++) begin
      unused_tri_z = unused_tri_z ^ (^tri_R16S[(v*AXIS+2)*SIGFIG +: SIGFIG]);
    end
  end

endmodule

// File: tb/tb_sampletest_multi.sv
// tb/tb_sampletest_multi.sv - randomized and directed self-checking bench for sampletest_multi
module tb_sampletest_multi;

  localparam int SF = 24, LN = 4, AX = 3, CL = 3, VT = 3, DEPTH = 4, EW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [VT*AX*SF-1:0]   tri_in;
  logic [CL*SF-1:0]      color_in;
  logic [LN*2*SF-1:0]    samp_in;
  logic [LN-1:0]         sv_in;
  logic                  cull_in;
  logic                  valid_in;
  logic                  ready_out;
  logic [LN*AX*SF-1:0]   hit_out;
  logic [CL*SF-1:0]      color_out;
  logic [LN-1:0]         mask_out;
  logic                  valid_out;
  logic                  ready_ds;
`ifdef SAMPLETEST_MULTI_CNT_EN
  logic [31:0]           cnt_tested;
  logic [31:0]           cnt_hit;
`endif

  sampletest_multi dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R16S       (tri_in),
    .color_R16U     (color_in),
    .sample_R16S    (samp_in),
    .sampValid_R16H (sv_in),
    .cull_R16H      (cull_in),
    .valid_R16H     (valid_in),
    .ready_R16H     (ready_out),
    .hit_R19S       (hit_out),
    .color_R19U     (color_out),
    .hitMask_R19H   (mask_out),
    .valid_R19H     (valid_out),
    .ready_R19H     (ready_ds)
`ifdef SAMPLETEST_MULTI_CNT_EN
   ,.cntTested_R19U (cnt_tested),
    .cntHit_R19U    (cnt_hit)
`endif
  );

  typedef struct {
    logic [LN*AX*SF-1:0] hit;
    logic [CL*SF-1:0]    color;
    logic [LN-1:0]       mask;
    int                  wr_edge;
  } beat_t;

  beat_t             pipe[$];
  beat_t             mfifo[$];
  logic [CL*SF-1:0]  pop_log[$];
  int                edge_n = 0;
  bit                up_m = 1'b0;
  bit                last_acc;
  int                n_acc = 0;
  int                n_pass = 0;
  int                n_checks = 0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint vc(input int v, input int a);
    return longint'($signed(tri_in[(v*AX+a)*SF +: SF]));
  endfunction

  function automatic longint sc(input int l, input int c);
    return longint'($signed(samp_in[(l*2+c)*SF +: SF]));
  endfunction

  function automatic longint tr(input longint v);
    logic signed [EW-1:0] t;
    t = v[EW-1:0];
    return longint'(t);
  endfunction

  // Reference: signed area of each edge seen from the sample, sign rules decide the hit
  function automatic beat_t model_beat();
    beat_t  b;
    longint d, xa, ya, xb, yb;
    int     vb;
    bit     neg, pos;
    b.hit = '0; b.color = color_in; b.mask = '0; b.wr_edge = 0;
    for (int l = 0; l < LN; l++) begin
      neg = 1'b1; pos = 1'b1;
      for (int e = 0; e < 3; e++) begin
        vb = (e + 1) % 3;
        xa = tr(vc(e, 0) - sc(l, 0));  ya = tr(vc(e, 1) - sc(l, 1));
        xb = tr(vc(vb, 0) - sc(l, 0)); yb = tr(vc(vb, 1) - sc(l, 1));
        d = xa * yb - xb * ya;
        if (!(d < 0)) neg = 1'b0;
        if (!(d > 0)) pos = 1'b0;
      end
      b.mask[l] = sv_in[l] && (neg || (!cull_in && pos));
      b.hit[(l*AX+0)*SF +: SF] = samp_in[(l*2+0)*SF +: SF];
      b.hit[(l*AX+1)*SF +: SF] = samp_in[(l*2+1)*SF +: SF];
      b.hit[(l*AX+2)*SF +: SF] = tri_in[2*SF +: SF];
    end
    return b;
  endfunction

  task automatic check_outputs();
    check("valid_R19H", 320'(valid_out), 320'(mfifo.size() != 0));
    check("ready_R16H", 320'(ready_out), 320'(up_m && (mfifo.size() + pipe.size() < DEPTH)));
    if (mfifo.size() != 0) begin
      check("hitMask", 320'(mask_out), 320'(mfifo[0].mask));
      check("hit", 320'(hit_out), 320'(mfifo[0].hit));
      check("color", 320'(color_out), 320'(mfifo[0].color));
    end
  endtask

  // Called at a falling edge with inputs already driven; advances one clock
  task automatic tick();
    beat_t nb;
    bit    pop;
    last_acc = rst && valid_in && (ready_out === 1'b1);
    pop      = (valid_out === 1'b1) && ready_ds;
    if (last_acc) begin
      nb = model_beat();
      nb.wr_edge = edge_n + 4;
      pipe.push_back(nb);
      n_acc++;
    end
    if (pop) begin
      pop_log.push_back(color_out);
      if (mfifo.size() != 0) void'(mfifo.pop_front());
    end
    @(posedge clk);
    edge_n++;
    if (!rst) begin
      pipe.delete(); mfifo.delete(); up_m = 1'b0;
    end else begin
      up_m = 1'b1;
      while (pipe.size() != 0 && pipe[0].wr_edge == edge_n) begin
        if (pipe[0].mask != '0) mfifo.push_back(pipe[0]);
        void'(pipe.pop_front());
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_vert(input int v, input int x, input int y, input int z);
    tri_in[(v*AX+0)*SF +: SF] = SF'(x);
    tri_in[(v*AX+1)*SF +: SF] = SF'(y);
    tri_in[(v*AX+2)*SF +: SF] = SF'(z);
  endtask

  task automatic set_samp(input int l, input int x, input int y);
    samp_in[(l*2+0)*SF +: SF] = SF'(x);
    samp_in[(l*2+1)*SF +: SF] = SF'(y);
  endtask

  task automatic set_t(input bit swapped);
    set_vert(0, 0, 0, 777);
    if (swapped) begin set_vert(1, 4096, 0, 5); set_vert(2, 0, 4096, 6); end
    else         begin set_vert(1, 0, 4096, 5); set_vert(2, 4096, 0, 6); end
  endtask

  function automatic int rc();
    if ($urandom_range(0, 9) == 0) return int'($urandom & 32'h00FF_FFFF);
    return int'($urandom_range(0, 8191));
  endfunction

  task automatic rand_beat();
    for (int v = 0; v < VT; v++) set_vert(v, rc(), rc(), int'($urandom_range(0, 65535)));
    for (int l = 0; l < LN; l++) set_samp(l, rc(), rc());
    sv_in    = 4'($urandom);
    cull_in  = 1'($urandom);
    color_in = {24'($urandom), 24'($urandom), 24'($urandom)};
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int waits, seen, acc_before;
  logic [LN*AX*SF-1:0] exp_hit;

  initial begin
    rst = 1'b0; valid_in = 1'b0; ready_ds = 1'b1; cull_in = 1'b0;
    tri_in = '0; samp_in = '0; sv_in = '0; color_in = '0;

    tick(); tick();
    check("reset_ready_low", 320'(ready_out), 320'(0));
    check("reset_valid_low", 320'(valid_out), 320'(0));
    rst = 1'b1;
    tick();
    check("ready_after_release", 320'(ready_out), 320'(1));

    // Hit / miss / edge case
    set_t(1'b0); cull_in = 1'b1; color_in = 72'h123;
    set_samp(0, 1024, 1024); set_samp(1, 5120, 5120); set_samp(2, 0, 2048); set_samp(3, 1024, 1024);
    sv_in = 4'b0111; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; waits = 0;
    while (valid_out !== 1'b1 && waits < 10) begin tick(); waits++; end
    check("latency", 320'(waits), 320'(3));
    check("hit_mask_0001", 320'(mask_out), 320'(4'b0001));
    exp_hit = '0;
    exp_hit[0 +: SF] = SF'(1024); exp_hit[SF +: SF] = SF'(1024); exp_hit[2*SF +: SF] = SF'(777);
    check("hit_lane0", 320'(hit_out[0 +: AX*SF]), 320'(exp_hit[0 +: AX*SF]));
    idle(3);

    // Culling: reversed winding
    set_t(1'b1); set_samp(0, 1024, 1024); sv_in = 4'b0001; cull_in = 1'b1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (valid_out === 1'b1) seen++; end
    check("culled_dropped", 320'(seen), 320'(0));
    cull_in = 1'b0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; waits = 0;
    while (valid_out !== 1'b1 && waits < 10) begin tick(); waits++; end
    check("unculled_mask", 320'(mask_out), 320'(4'b0001));
    idle(3);

    // Degenerate triangle
    for (int v = 0; v < VT; v++) set_vert(v, 2048, 2048, 9);
    sv_in = 4'b1111; cull_in = 1'b0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (valid_out === 1'b1) seen++; end
    check("degenerate_dropped", 320'(seen), 320'(0));
    check("degenerate_ready", 320'(ready_out), 320'(1));

    // Back-pressure
    set_t(1'b0); set_samp(0, 1024, 1024); sv_in = 4'b0001; cull_in = 1'b1;
    ready_ds = 1'b0; acc_before = n_acc; valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin color_in = 72'(n_acc - acc_before); tick(); end
    check("bp_accepted", 320'(n_acc - acc_before), 320'(4));
    check("bp_ready_low", 320'(ready_out), 320'(0));
    pop_log.delete(); ready_ds = 1'b1; acc_before = n_acc;
    for (int i = 0; i < 12; i++) begin color_in = 72'(100 + i); tick(); end
    check("bp_pop_count", 320'(pop_log.size() >= 4), 320'(1));
    for (int i = 0; i < 4; i++) check("bp_order", 320'(pop_log[i]), 320'(i));
    check("bp_resumed", 320'(n_acc > acc_before), 320'(1));
    idle(10);

    // Reset mid-stream: two buffered, two in flight
    ready_ds = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin color_in = 72'(200 + i); tick(); end
    idle(1);
    check("pre_reset_valid", 320'(valid_out), 320'(1));
    rst = 1'b0;
    tick();
    check("mid_reset_valid", 320'(valid_out), 320'(0));
    check("mid_reset_ready", 320'(ready_out), 320'(0));
    rst = 1'b1; ready_ds = 1'b1;
    tick();
    check("post_reset_ready", 320'(ready_out), 320'(1));
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (valid_out === 1'b1) seen++; end
    check("no_stale_output", 320'(seen), 320'(0));

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rand_beat();
      valid_in = ($urandom_range(0, 3) != 0);
      ready_ds = ($urandom_range(0, 3) != 0);
      tick();
    end
    ready_ds = 1'b1;
    idle(12);

`ifdef SAMPLETEST_MULTI_CNT_EN
    rst = 1'b0; tick();
    rst = 1'b1; tick();
    check("cnt_reset", 320'({cnt_tested, cnt_hit}), 320'(64'd0));
    set_t(1'b0); cull_in = 1'b1; sv_in = 4'b1111;
    set_samp(0, 1024, 1024); set_samp(1, 5120, 5120); set_samp(2, 1024, 1024); set_samp(3, 5120, 5120);
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idle(8);
    check("cnt_tested", 320'(cnt_tested), 320'(12));
    check("cnt_hit", 320'(cnt_hit), 320'(6));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sampletest_multi.md
# sampletest_multi

- Multi-lane, handshaked successor to the single-sample triangle sample test.
- Per beat: accepts one triangle, one color and `LANES` sample positions.
- Evaluates three edge equations per lane with optional back-face culling, then emits a per-lane hit mask with hit locations.
- Sits between the sample iterator and the z-buffer/shader stage. Buffers results in an output FIFO guarded by credit-based back-pressure.

## Interface
Parameters:
- SIGFIG, 24, bits in color/position
- RADIX, 10, fraction bits
- VERTS, 3, vertices per triangle (only 3 supported)
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- LANES, 4, samples tested per beat
- FIFO_DEPTH, 4, output buffer entries; must be ≥4 for full throughput

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- tri_R16S  in  [VERTS][AXIS]×SIGFIG signed  triangle
- color_R16U  in  [COLORS]×SIGFIG  triangle color
- sample_R16S  in  [LANES][2]×SIGFIG signed  sample x,y per lane (unjittered)
- sampValid_R16H  in  LANES  per-lane sample valid
- cull_R16H  in  1  back-face culling enable for this beat
- valid_R16H  in  1  input beat valid
- ready_R16H  out  1  input beat accepted when valid&&ready
- hit_R19S  out  [LANES][AXIS]×SIGFIG signed  per-lane x,y = sample, z = tri v0 z
- color_R19U  out  [COLORS]×SIGFIG  color
- hitMask_R19H  out  LANES  per-lane hit
- valid_R19H  out  1  output beat valid
- ready_R19H  in  1  downstream accepts

## Operation
- Stage A, edge 1:
  - shift each vertex by the lane sample: sx = x − xs, sy = y − ys, SIGFIG-bit two's-complement.
  - Truncate to the low SIGFIG−4 bits, signed.
- Stage B, edge 2: per lane, per edge (a,b) ∈ {(0,1),(1,2),(2,0)}:
  - dist = sx_a·sy_b − sx_b·sy_a.
  - Products are 2·(SIGFIG−4) bits; dist is 2·(SIGFIG−4)+1 bits, with no overflow.
- Stage C, edge 3: hit classification per lane.
  - cull=1: hit = sampValid && all three dist < 0.
  - cull=0: hit = sampValid && (all dist < 0 || all dist > 0).
  - Any dist == 0 means a miss, including degenerate triangles.
- Culled beats: if hitMask == 0, the beat is dropped and not written to the FIFO. Its credit is released at edge 3.
- Credits:
  - inflight = beats in stages A–C.
  - ready_R16H = (fifo_count + inflight) < FIFO_DEPTH.
  - ready_R16H is a function of registers only; no combinational path from valid_R16H or ready_R19H.
- FIFO:
  - The pipeline never stalls; overflow is impossible by the credit rule.
  - Simultaneous write and pop is legal at any occupancy, including full.
  - Order is preserved.
- z comes from vertex 0, with no interpolation.

## Timing
- Latency: beat accepted at edge 0 → valid_R19H high in the cycle after edge 3 (3 cycles), FIFO empty case; no FIFO bypass.
- Throughput: 1 beat/cycle while ready_R19H=1 and FIFO_DEPTH≥4.
- valid_R19H/data hold stable until ready_R19H; pop on valid&&ready.
- Reset (rst=0 at an edge):
  - all stage valids cleared, FIFO emptied, valid_R19H=0, ready_R16H=0 during reset, counters 0.
  - ready_R16H=1 in the first cycle after release.
  - Data registers are not reset.
- Reset mid-operation: in-flight and buffered beats are discarded, with no partial output.

## Configuration
- `SAMPLETEST_MULTI_CNT_EN` defined: adds ports cntTested_R19U (out, 32) and cntHit_R19U (out, 32).
  - cntTested_R19U: lanes with sampValid per accepted beat.
  - cntHit_R19U: hit lanes written to the FIFO.
  - Both update at stage C, wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package sampletest_multi_pkg holds:
  - localparams EDGES=3, EW=SIGFIG−4, DW=2·EW+1;
  - typedef of the stage-C payload struct (hit coords, color, mask);
  - edge vertex-index table.
- One sub-module, sampletest_obuf: parametrised FIFO (width, FIFO_DEPTH) exposing count for the credit logic.

## Test plan
Coordinates are in units with 1.0 = 1024. Triangle T = v0(0,0), v1(0,4096), v2(4096,0); Tr = T with v1 and v2 swapped.

- Hit/miss/edge case:
  - Stimulus: T, cull=1, lanes (1024,1024), (5120,5120), (0,2048), (1024,1024) with lane 3 sampValid=0.
  - Required: hitMask=0001b, hit_R19S[0]=(1024,1024,z_v0), 3 cycles after accept.
- Culling:
  - Stimulus: Tr, lane 0 at (1024,1024).
  - Required: cull=1 → no output beat (dropped); cull=0 → hitMask[0]=1.
- Degenerate:
  - Stimulus: all vertices at (2048,2048), any samples.
  - Required: beat dropped, ready_R16H returns high.
- Back-pressure:
  - Stimulus: ready_R19H=0, 8 consecutive hitting beats.
  - Required: exactly 4 accepted; ready_R16H low thereafter. On release, the 4 beats emerge in order and acceptance resumes at 1/cycle.
- Reset mid-stream:
  - Stimulus: rst=0 for one edge with 2 beats in flight and 2 buffered.
  - Required: valid_R19H=0 next cycle; nothing stale emitted; ready_R16H=1 after release.
- Counters (macro defined):
  - Stimulus: 3 beats with 4 valid lanes, 2 hits each.
  - Required: cntTested=12, cntHit=6.
